// File: rtl/clk_interval_timer.sv
// Multi-channel start/stop interval timer: per-channel cycle counter with live count,
// captured last-interval result, restart/accumulate mode and saturating or wrapping overflow.
module clk_interval_timer #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter bit SAT   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       stop,
  input  logic [NCH-1:0]       clear,
  input  logic [NCH-1:0]       accum,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH*WIDTH-1:0] last,
  output logic [NCH-1:0]       running,
  output logic [NCH-1:0]       done,
  output logic [NCH-1:0]       overflow
);

  typedef enum logic {IDLE, RUN} state_e;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   last_q, last_d;
    logic [WIDTH-1:0]   inc_val;
    logic               at_max;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    // Incrementing from all-ones either pins at all-ones or rolls to zero.
    assign at_max  = &count_q;
    assign inc_val = at_max ? {WIDTH{SAT}} : count_q + WIDTH'(1);

    always_comb begin
      state_d = state_q;
      count_d = count_q;
      last_d  = last_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      if (clear[gi]) begin
        state_d = IDLE;
        count_d = '0;
        ovf_d   = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start[gi] && !stop[gi]) begin
              state_d = RUN;
              if (!accum[gi]) count_d = '0;
            end
          end
          RUN: begin
            count_d = inc_val;
            ovf_d   = ovf_q | at_max;
            if (stop[gi]) begin
              state_d = IDLE;
              last_d  = inc_val;
              done_d  = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        count_q <= '0;
        last_q  <= '0;
        done_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
        last_q  <= last_d;
        done_q  <= done_d;
        ovf_q   <= ovf_d;
      end
    end

    assign count[gi*WIDTH +: WIDTH] = count_q;
    assign last[gi*WIDTH +: WIDTH]  = last_q;
    assign running[gi]              = (state_q == RUN);
    assign done[gi]                 = done_q;
    assign overflow[gi]             = ovf_q;
  end

endmodule

// File: tb/tb_clk_interval_timer.sv
// Bench for clk_interval_timer: directed scenarios plus random traffic against an
// interval-arithmetic reference model; two narrow instances exercise saturate and wrap.
module tb_clk_interval_timer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   start = '0, stop = '0, clear = '0, accum = '0;
  logic [127:0] count, last;
  logic [3:0]   running, done, overflow;
  logic [3:0]   count_s, last_s, count_w, last_w;
  logic         running_s, done_s, ovf_s, running_w, done_w, ovf_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_interval_timer #(.WIDTH(32), .NCH(4), .SAT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear), .accum(accum),
    .count(count), .last(last), .running(running), .done(done), .overflow(overflow));

  clk_interval_timer #(.WIDTH(4), .NCH(1), .SAT(1'b1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start[0:0]), .stop(stop[0:0]), .clear(clear[0:0]),
    .accum(accum[0:0]), .count(count_s), .last(last_s), .running(running_s), .done(done_s),
    .overflow(ovf_s));

  clk_interval_timer #(.WIDTH(4), .NCH(1), .SAT(1'b0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .start(start[0:0]), .stop(stop[0:0]), .clear(clear[0:0]),
    .accum(accum[0:0]), .count(count_w), .last(last_w), .running(running_w), .done(done_w),
    .overflow(ovf_w));

  // Reference model: channels 0..3 main instance, 4 saturating narrow, 5 wrapping narrow.
  // A running channel's count is derived from (base + cycles elapsed since start edge).
  bit     m_run[6], m_ovf[6], m_done[6];
  longint m_base[6], m_k[6], m_idle[6], m_last[6];
  int     m_w[6]   = '{32, 32, 32, 32, 4, 4};
  bit     m_sat[6] = '{1, 1, 1, 1, 1, 0};
  longint edge_cnt = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_bit(input logic [3:0] v, input int c);
    return (c < 4) ? v[c] : v[0];
  endfunction

  function automatic void model_value(input int c, output longint v, output bit o);
    longint maxv = (longint'(1) << m_w[c]) - 1;
    longint raw  = m_base[c] + (edge_cnt - m_k[c]);
    o = (raw > maxv);
    if (!o)            v = raw;
    else if (m_sat[c]) v = maxv;
    else               v = raw % (maxv + 1);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 6; c++) begin
      m_run[c] = 0; m_ovf[c] = 0; m_done[c] = 0;
      m_base[c] = 0; m_k[c] = 0; m_idle[c] = 0; m_last[c] = 0;
    end
  endfunction

  function automatic void model_edge();
    longint v;
    bit     o;
    edge_cnt++;
    for (int c = 0; c < 6; c++) begin
      m_done[c] = 0;
      if (in_bit(clear, c)) begin
        m_run[c] = 0; m_idle[c] = 0; m_ovf[c] = 0;
      end else if (m_run[c]) begin
        if (in_bit(stop, c)) begin
          model_value(c, v, o);
          m_last[c] = v; m_idle[c] = v; m_ovf[c] = m_ovf[c] | o;
          m_run[c] = 0; m_done[c] = 1;
        end
      end else if (in_bit(start, c) && !in_bit(stop, c)) begin
        m_run[c]  = 1;
        m_base[c] = in_bit(accum, c) ? m_idle[c] : 0;
        m_k[c]    = edge_cnt;
      end
    end
  endfunction

  task automatic compare_all();
    longint v, oc, ol, exp_cnt;
    bit     o, orun, odone, oovf;
    for (int c = 0; c < 6; c++) begin
      case (c)
        4: begin oc = count_s; ol = last_s; orun = running_s; odone = done_s; oovf = ovf_s; end
        5: begin oc = count_w; ol = last_w; orun = running_w; odone = done_w; oovf = ovf_w; end
        default: begin
          oc = count[c*32 +: 32]; ol = last[c*32 +: 32];
          orun = running[c]; odone = done[c]; oovf = overflow[c];
        end
      endcase
      o = 0;
      exp_cnt = m_idle[c];
      if (m_run[c]) model_value(c, exp_cnt, o);
      v = exp_cnt;
      check_eq($sformatf("ch%0d_count", c), oc, v);
      check_eq($sformatf("ch%0d_last", c), ol, m_last[c]);
      check_eq($sformatf("ch%0d_running", c), longint'(orun), longint'(m_run[c]));
      check_eq($sformatf("ch%0d_done", c), longint'(odone), longint'(m_done[c]));
      check_eq($sformatf("ch%0d_overflow", c), longint'(oovf), longint'(m_ovf[c] | o));
    end
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_ticks(input int n);
    start = '0; stop = '0; clear = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_count", longint'(count[31:0]), 0);
    check_eq("reset_running", longint'(running), 0);
    reset_n = 1'b1;
    idle_ticks(1);

    // 1) ch0 restart mode, stop 10 edges after start
    accum = 4'b0000;
    start = 4'b0001; tick();
    idle_ticks(9);
    stop = 4'b0001; tick();
    check_eq("t1_last0", longint'(last[31:0]), 10);
    check_eq("t1_done0", longint'(done[0]), 1);
    check_eq("t1_running0", longint'(running[0]), 0);
    idle_ticks(1);
    check_eq("t1_done0_once", longint'(done[0]), 0);

    // 2) ch1 accumulate: 5 then 7 cycles
    accum = 4'b0010;
    start = 4'b0010; tick(); idle_ticks(4);
    stop = 4'b0010; tick();
    check_eq("t2_last1_a", longint'(last[63:32]), 5);
    start = 4'b0010; stop = '0; tick(); idle_ticks(6);
    stop = 4'b0010; tick();
    check_eq("t2_last1_b", longint'(last[63:32]), 12);
    idle_ticks(3);
    check_eq("t2_count1_hold", longint'(count[63:32]), 12);
    accum = '0;

    // 3) start+stop together in IDLE, then stop alone
    start = 4'b0100; stop = 4'b0100; tick();
    check_eq("t3_running2", longint'(running[2]), 0);
    check_eq("t3_count2", longint'(count[95:64]), 0);
    start = '0; tick();
    check_eq("t3_done2", longint'(done[2]), 0);

    // 4) 20-cycle interval on ch0: narrow instances saturate / wrap
    start = 4'b0001; stop = '0; tick(); idle_ticks(19);
    stop = 4'b0001; tick();
    check_eq("t4_last0", longint'(last[31:0]), 20);
    check_eq("t4_sat_last", longint'(last_s), 15);
    check_eq("t4_sat_ovf", longint'(ovf_s), 1);
    check_eq("t4_wrap_last", longint'(last_w), 4);
    check_eq("t4_wrap_ovf", longint'(ovf_w), 1);

    // 5) clear ch3 at count 6, then clear+start together
    start = 4'b1000; stop = '0; tick(); idle_ticks(6);
    check_eq("t5_count3_pre", longint'(count[127:96]), 6);
    clear = 4'b1000; tick();
    check_eq("t5_count3", longint'(count[127:96]), 0);
    check_eq("t5_running3", longint'(running[3]), 0);
    check_eq("t5_done3", longint'(done[3]), 0);
    clear = 4'b1000; start = 4'b1000; tick();
    check_eq("t5_clr_start", longint'(running[3]), 0);
    idle_ticks(1);

    // 6) asynchronous reset between edges mid-interval
    start = 4'b1111; tick(); idle_ticks(3);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_count", longint'(count != '0), 0);
    check_eq("t6_rst_last", longint'(last != '0), 0);
    check_eq("t6_rst_flags", longint'({running, done, overflow} != '0), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle_ticks(1);

    // Random overlapping traffic on all channels
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 4; c++) begin
        start[c] = ($urandom % 6) == 0;
        stop[c]  = ($urandom % 9) == 0;
        clear[c] = ($urandom % 60) == 0;
        accum[c] = $urandom % 2;
      end
      tick();
    end
    idle_ticks(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
